// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: funct3 size codes, memory opcodes and the
// load/store unit state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it according to funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data_c = '0;
    case (funct3)
      F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_c = rdata;
      F3_BU:   data_c = {24'd0, byte_sel};
      F3_HU:   data_c = {16'd0, half_sel};
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle data-memory access unit: captures one request, issues a held
// word-aligned memory request, and returns extended load data or a fault.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            access_fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t state_q, state_d;

  logic            write_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;

  logic            legal_c;
  logic            accept_c;
  logic [XLEN-1:0] lane_wdata_c;
  logic [3:0]      lane_be_c;
  logic [XLEN-1:0] ext_c;

  assign accept_c = (state_q == IDLE) && req_valid;

  // Legality of the incoming request: funct3 allowed for direction, plus alignment.
  always_comb begin
    legal_c = 1'b0;
    case (req_funct3)
      F3_B:    legal_c = 1'b1;
      F3_H:    legal_c = ~req_addr[0];
      F3_W:    legal_c = (req_addr[1:0] == 2'b00);
      F3_BU:   legal_c = ~req_write;
      F3_HU:   legal_c = ~req_write & ~req_addr[0];
      default: legal_c = 1'b0;
    endcase
  end

  // Store lane replication and byte enables from the captured request.
  always_comb begin
    lane_wdata_c = wdata_q;
    lane_be_c    = 4'b0000;
    case (funct3_q)
      F3_B: begin
        lane_wdata_c = {4{wdata_q[7:0]}};
        lane_be_c    = 4'b0001 << addr_q[1:0];
      end
      F3_H: begin
        lane_wdata_c = {2{wdata_q[15:0]}};
        lane_be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        lane_wdata_c = wdata_q;
        lane_be_c    = 4'b1111;
      end
      default: begin
        lane_wdata_c = wdata_q;
        lane_be_c    = 4'b0000;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data_c  (ext_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    access_fault = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = legal_c ? ACCESS : FAULT;
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        mem_wdata = lane_wdata_c;
        mem_be    = write_q ? lane_be_c : 4'b0000;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      FAULT: begin
        resp_valid   = 1'b1;
        access_fault = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and response data; resp_rdata holds until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept_c) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (!legal_c) resp_rdata <= '0;
      end
      if ((state_q == ACCESS) && mem_ack) begin
        resp_rdata <= write_q ? '0 : ext_c;
      end
    end
  end

endmodule
